// File: rtl/viterbi_ber_lock_checker_if.sv
// -----------------------------------------------------------------------------
// viterbi_ber_lock_checker_if
// Bit-stream and status bundle between the Viterbi BER lock checker and
// whatever drives it (the tx/rx chain wrapper, or a bench).
//
//   en_i         bit strobe; ref_bit_i and dec_bit_i are valid this cycle
//   ref_bit_i    original data (encoder input)
//   dec_bit_i    decoded data (decoder output)
//   search_en_i  1 = automatic latency search, 0 = use latency_i
//   latency_i    fixed latency candidate for non-search mode
//   clear_i      soft clear, same effect as reset
//   locked_o     alignment locked
//   latency_o    current candidate / locked latency
//   good_o       matching bits counted while locked (saturating)
//   bad_o        mismatching bits counted while locked (saturating)
//   acq_fail_o   sticky: a full candidate sweep finished without lock
//
// master drives the bit stream and controls; slave is the checker.
// -----------------------------------------------------------------------------
interface viterbi_ber_lock_checker_if #(
    parameter int LW    = 6,
    parameter int CNT_W = 16
);
    logic             en_i;
    logic             ref_bit_i;
    logic             dec_bit_i;
    logic             search_en_i;
    logic [LW-1:0]    latency_i;
    logic             clear_i;
    logic             locked_o;
    logic [LW-1:0]    latency_o;
    logic [CNT_W-1:0] good_o;
    logic [CNT_W-1:0] bad_o;
    logic             acq_fail_o;

    modport master (
        output en_i, ref_bit_i, dec_bit_i, search_en_i, latency_i, clear_i,
        input  locked_o, latency_o, good_o, bad_o, acq_fail_o
    );

    modport slave (
        input  en_i, ref_bit_i, dec_bit_i, search_en_i, latency_i, clear_i,
        output locked_o, latency_o, good_o, bad_o, acq_fail_o
    );
endinterface

// File: rtl/viterbi_ber_lock_checker.sv
// -----------------------------------------------------------------------------
// viterbi_ber_lock_checker
// Aligns the Viterbi decoder output against a history of encoder input bits,
// finds the decoder latency (automatic sweep or fixed), declares lock after
// LOCK_WIN consecutive matches, then counts good/bad bits and drops lock when
// LOSS_THR mismatches land in one LOCK_WIN-compare block.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-low reset
//   bus   viterbi_ber_lock_checker_if.slave (bit stream, controls, status)
//
// Time only advances on bus.en_i cycles. All status outputs are registered:
// a compare made in one enabled cycle is visible after the next clock edge.
// -----------------------------------------------------------------------------
module viterbi_ber_lock_checker #(
    parameter int LAT_MAX  = 64,
    parameter int LOCK_WIN = 32,
    parameter int LOSS_THR = 4,
    parameter int CNT_W    = 16,
    parameter int LW       = $clog2(LAT_MAX)
) (
    input logic                      clk,
    input logic                      rst,
    viterbi_ber_lock_checker_if.slave bus
);

    localparam int FW = $clog2(LAT_MAX + 1);
    localparam int RW = $clog2(LOCK_WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [LAT_MAX-1:0] hist;
    logic [FW-1:0]    fill;
    logic [LW-1:0]    cand;
    logic [RW-1:0]    match_run;
    logic [RW-1:0]    blk_cnt;
    logic [EW-1:0]    blk_err;
    logic             locked;
    logic             acq_fail;
    logic [CNT_W-1:0] good;
    logic [CNT_W-1:0] bad;

    logic             tap;
    logic             cmp_valid;
    logic             mismatch;
    logic [LW-1:0]    cand_m1;
    logic [LW-1:0]    cand_inc;
    logic             cand_wrap;
    logic [RW-1:0]    blk_cnt_nxt;
    logic [EW-1:0]    blk_err_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [FW-1:0] fill_inc(input logic [FW-1:0] v);
        return (v == FW'(LAT_MAX)) ? v : v + FW'(1);
    endfunction

    // Candidate tap, compare validity and block bookkeeping for this cycle
    always_comb begin
        cand_m1     = cand - LW'(1);
        tap         = (cand == '0) ? bus.ref_bit_i : hist[cand_m1];
        // A candidate can only be judged once the history is deep enough for it
        cmp_valid   = bus.en_i && (FW'(cand) <= fill);
        mismatch    = tap ^ bus.dec_bit_i;
        cand_wrap   = (cand == LW'(LAT_MAX - 1));
        cand_inc    = cand_wrap ? '0 : cand + LW'(1);
        // A full block rolls over into a fresh one on the next compare
        if (blk_cnt == RW'(LOCK_WIN)) begin
            blk_cnt_nxt = RW'(1);
            blk_err_nxt = EW'(mismatch);
        end else begin
            blk_cnt_nxt = blk_cnt + RW'(1);
            blk_err_nxt = blk_err + EW'(mismatch);
        end
    end

    // Reference history: data only, validity is tracked by fill
    always_ff @(posedge clk) begin
        if (bus.en_i) begin
            hist <= {hist[LAT_MAX-2:0], bus.ref_bit_i};
        end
    end

    // Control FSM and status registers
    always_ff @(posedge clk) begin
        if (!rst || bus.clear_i) begin
            state     <= IDLE;
            fill      <= '0;
            cand      <= '0;
            match_run <= '0;
            blk_cnt   <= '0;
            blk_err   <= '0;
            locked    <= 1'b0;
            acq_fail  <= 1'b0;
            good      <= '0;
            bad       <= '0;
        end else if (bus.en_i) begin
            fill <= fill_inc(fill);
            case (state)
                IDLE: begin
                    state <= ACQ;
                    cand  <= bus.search_en_i ? '0 : bus.latency_i;
                end
                ACQ: begin
                    if (cmp_valid) begin
                        if (!mismatch) begin
                            if (match_run == RW'(LOCK_WIN - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_run <= '0;
                                blk_cnt   <= '0;
                                blk_err   <= '0;
                            end else begin
                                match_run <= match_run + RW'(1);
                            end
                        end else begin
                            match_run <= '0;
                            if (bus.search_en_i) begin
                                cand <= cand_inc;
                                if (cand_wrap) begin
                                    acq_fail <= 1'b1;
                                end
                            end else begin
                                cand <= bus.latency_i;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (cmp_valid) begin
                        if (mismatch) begin
                            bad <= sat_inc(bad);
                        end else begin
                            good <= sat_inc(good);
                        end
                        blk_cnt <= blk_cnt_nxt;
                        blk_err <= blk_err_nxt;
                        // cand is left alone so the lost latency is retried first
                        if (blk_err_nxt == EW'(LOSS_THR)) begin
                            state     <= ACQ;
                            locked    <= 1'b0;
                            match_run <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.locked_o   = locked;
    assign bus.latency_o  = cand;
    assign bus.good_o     = good;
    assign bus.bad_o      = bad;
    assign bus.acq_fail_o = acq_fail;

endmodule
